// File: rtl/cmsdk_ahb_to_fpga_mem.sv
// AHB-Lite slave front end for FPGA block memories: zero-wait reads issued in the address
// phase, writes committed directly or via a one-entry buffer with read-after-write merging.
module cmsdk_ahb_to_fpga_mem #(
    parameter int unsigned AW       = 16,
    parameter bit          WRITE_EN = 1'b1
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-3:0] MEMADDR,
    output logic [31:0]   MEMWDATA,
    output logic [3:0]    MEMWREN,
    output logic          MEMCS,
    input  logic [31:0]   MEMRDATA
);

    localparam int unsigned WW = AW - 2;

    typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]    wr_lanes_q, wr_lanes_d;
    logic          wr_dphase_q, wr_dphase_d;
    logic          buf_pend_q, buf_pend_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic          rd_dphase_q, rd_dphase_d;
    logic          hit_q, hit_d;

    logic          trans_valid;
    logic          rd_aphase;
    logic          wr_aphase;
    logic [3:0]    lanes;
    logic [31:0]   rdata_merged;
    logic          unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Gated by reset so the memory port is quiet while reset is asserted.
    assign trans_valid = ~HRESET & HSEL & HREADY & HTRANS[1];
    assign rd_aphase   = trans_valid & ~HWRITE;
    assign wr_aphase   = trans_valid & HWRITE;

    always_comb begin
        lanes = 4'b1111;
        case (HSIZE)
            3'b000:  lanes = 4'b0001 << HADDR[1:0];
            3'b001:  lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_lanes_d  = wr_lanes_q;
        wr_dphase_d = wr_dphase_q;
        buf_pend_d  = buf_pend_q;
        buf_data_d  = buf_data_q;
        rd_dphase_d = rd_dphase_q;
        hit_d       = hit_q;

        case (state_q)
            StErr1:  state_d = StErr2;
            default: state_d = (wr_aphase && !WRITE_EN) ? StErr1 : StIdle;
        endcase

        if (HREADY) begin
            wr_dphase_d = wr_aphase & WRITE_EN;
            rd_dphase_d = rd_aphase;
        end

        if (wr_aphase && WRITE_EN) begin
            wr_addr_d  = HADDR[AW-1:2];
            wr_lanes_d = lanes;
        end

        if (rd_aphase) begin
            hit_d = (HADDR[AW-1:2] == wr_addr_q) & (buf_pend_q | wr_dphase_q);
        end

        // The memory port is taken by the read, so park the write data.
        if (wr_dphase_q && rd_aphase) begin
            buf_data_d = HWDATA;
            buf_pend_d = 1'b1;
        end else if (buf_pend_q && !rd_aphase) begin
            buf_pend_d = 1'b0;
        end
    end

    always_comb begin
        MEMCS    = 1'b0;
        MEMADDR  = '0;
        MEMWDATA = '0;
        MEMWREN  = '0;
        if (rd_aphase) begin
            MEMCS   = 1'b1;
            MEMADDR = HADDR[AW-1:2];
        end else if (wr_dphase_q) begin
            MEMCS    = 1'b1;
            MEMADDR  = wr_addr_q;
            MEMWDATA = HWDATA;
            MEMWREN  = wr_lanes_q;
        end else if (buf_pend_q) begin
            MEMCS    = 1'b1;
            MEMADDR  = wr_addr_q;
            MEMWDATA = buf_data_q;
            MEMWREN  = wr_lanes_q;
        end
    end

    always_comb begin
        rdata_merged = MEMRDATA;
        for (int i = 0; i < 4; i++) begin
            if (hit_q && wr_lanes_q[i]) begin
                rdata_merged[8*i +: 8] = buf_data_q[8*i +: 8];
            end
        end
    end

    assign HRDATA    = rd_dphase_q ? rdata_merged : '0;
    assign HREADYOUT = (state_q != StErr1);
    assign HRESP     = (state_q != StIdle);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            wr_lanes_q  <= '0;
            wr_dphase_q <= 1'b0;
            buf_pend_q  <= 1'b0;
            buf_data_q  <= '0;
            rd_dphase_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_lanes_q  <= wr_lanes_d;
            wr_dphase_q <= wr_dphase_d;
            buf_pend_q  <= buf_pend_d;
            buf_data_q  <= buf_data_d;
            rd_dphase_q <= rd_dphase_d;
            hit_q       <= hit_d;
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_to_fpga_mem.sv
// Bench for cmsdk_ahb_to_fpga_mem: a RAM and a ROM instance, each with a behavioural block memory.
module tb_cmsdk_ahb_to_fpga_mem;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BS = 2'b01;
    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [15:0] addr;
        bit [31:0] wdata;
        bit [31:0] erd;
        bit        ecs;
        bit [3:0]  ewren;
        bit [13:0] emaddr;
        bit [31:0] emwdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        use_rom;
    logic        hsel;
    logic        hready;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [15:0] haddr;
    logic [31:0] hwdata;

    logic        ram_hreadyout, ram_hresp, ram_cs;
    logic [31:0] ram_hrdata, ram_mwdata, ram_rdata;
    logic [13:0] ram_maddr;
    logic [3:0]  ram_wren;
    logic        rom_hreadyout, rom_hresp, rom_cs;
    logic [31:0] rom_hrdata, rom_mwdata, rom_rdata;
    logic [13:0] rom_maddr;
    logic [3:0]  rom_wren;

    logic [31:0] ram_mem [16384];
    logic [31:0] rom_mem [16384];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    vec_t        tbl [$];

    always #5 clk = ~clk;

    assign hready = use_rom ? rom_hreadyout : ram_hreadyout;

    cmsdk_ahb_to_fpga_mem #(.AW(16), .WRITE_EN(1'b1)) u_ram (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~use_rom), .HREADY(hready), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HREADYOUT(ram_hreadyout), .HRESP(ram_hresp), .HRDATA(ram_hrdata),
        .MEMADDR(ram_maddr), .MEMWDATA(ram_mwdata), .MEMWREN(ram_wren), .MEMCS(ram_cs),
        .MEMRDATA(ram_rdata)
    );

    cmsdk_ahb_to_fpga_mem #(.AW(16), .WRITE_EN(1'b0)) u_rom (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel & use_rom), .HREADY(hready), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HREADYOUT(rom_hreadyout), .HRESP(rom_hresp), .HRDATA(rom_hrdata),
        .MEMADDR(rom_maddr), .MEMWDATA(rom_mwdata), .MEMWREN(rom_wren), .MEMCS(rom_cs),
        .MEMRDATA(rom_rdata)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) begin
                ram_mem[i] <= 32'h0;
                rom_mem[i] <= {16'hCAFE, 16'(i)};
            end
        end else begin
            if (ram_cs) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_wren[i]) ram_mem[ram_maddr][8*i +: 8] <= ram_mwdata[8*i +: 8];
                end
                ram_rdata <= ram_mem[ram_maddr];
            end
            if (rom_cs) begin
                for (int i = 0; i < 4; i++) begin
                    if (rom_wren[i]) rom_mem[rom_maddr][8*i +: 8] <= rom_mwdata[8*i +: 8];
                end
                rom_rdata <= rom_mem[rom_maddr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit [1:0] tr, input bit wr, input bit [2:0] sz,
                         input bit [15:0] a, input bit [31:0] wd);
        @(posedge clk);
        #1;
        hsel   = sel;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
    endtask

    function automatic vec_t mk(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz, bit [15:0] a,
                                bit [31:0] wd, bit [31:0] erd, bit ecs, bit [3:0] ew,
                                bit [13:0] ema, bit [31:0] emw);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
        v.erd = erd; v.ecs = ecs; v.ewren = ew; v.emaddr = ema; v.emwdata = emw;
        return v;
    endfunction

    task automatic check_ram_reset(input string tag);
        check({tag, " hreadyout"}, 32'(ram_hreadyout), 32'h1);
        check({tag, " hresp"}, 32'(ram_hresp), 32'h0);
        check({tag, " hrdata"}, ram_hrdata, 32'h0);
        check({tag, " memcs"}, 32'(ram_cs), 32'h0);
        check({tag, " memwren"}, 32'(ram_wren), 32'h0);
        check({tag, " memaddr"}, 32'(ram_maddr), 32'h0);
        check({tag, " memwdata"}, ram_mwdata, 32'h0);
    endtask

    initial begin
        bit          prev_wr = 1'b0;
        bit [31:0]   prev_wd = '0;
        bit          dp_rd   = 1'b0;
        bit          cur_rd;
        bit          is_rd;
        string       nm;

        rst = 1'b1; mem_init = 1'b1; use_rom = 1'b0;
        hsel = 1'b0; htrans = ID; hwrite = 1'b0; hsize = SW; haddr = '0; hwdata = '0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check_ram_reset("reset");
        check("reset rom hresp", 32'(rom_hresp), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // sel trans wr size addr wdata | exp_hrdata exp_cs exp_wren exp_memaddr exp_memwdata
        tbl.push_back(mk(1, NS, 1, SW, 16'h0010, 32'h12345678, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 1, 4'hF, 14'h4, 32'h12345678));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0010, '0, 32'h12345678, 1, 4'h0, 14'h4, '0));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, NS, 1, SW, 16'h0020, 32'hAABBCCDD, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0020, '0, 32'hAABBCCDD, 1, 4'h0, 14'h8, '0));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 1, 4'hF, 14'h8, 32'hAABBCCDD));
        tbl.push_back(mk(1, NS, 1, SW, 16'h0030, 32'h11223344, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 1, 4'hF, 14'hC, 32'h11223344));
        tbl.push_back(mk(1, NS, 1, SB, 16'h0031, 32'h0000EE00, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0030, '0, 32'h1122EE44, 1, 4'h0, 14'hC, '0));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 1, 4'b0010, 14'hC, 32'h0000EE00));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0030, '0, 32'h1122EE44, 1, 4'h0, 14'hC, '0));
        tbl.push_back(mk(1, NS, 1, SH, 16'h0042, 32'hBEEF0000, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0010, '0, 32'h12345678, 1, 4'h0, 14'h4, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0020, '0, 32'hAABBCCDD, 1, 4'h0, 14'h8, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0030, '0, 32'h1122EE44, 1, 4'h0, 14'hC, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0040, '0, 32'hBEEF0000, 1, 4'h0, 14'h10, '0));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0000, '0, 32'h00000000, 1, 4'h0, 14'h0, '0));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 1, 4'b1100, 14'h10, 32'hBEEF0000));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0040, '0, 32'hBEEF0000, 1, 4'h0, 14'h10, '0));
        tbl.push_back(mk(1, BS, 0, SW, 16'h0010, '0, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, NS, 1, SB, 16'h0003, 32'h77000000, '0, 0, 4'h0, '0, '0));
        tbl.push_back(mk(1, NS, 1, SH, 16'h0000, 32'h00005555, '0, 1, 4'b1000, 14'h0,
                         32'h77000000));
        tbl.push_back(mk(1, NS, 0, SW, 16'h0000, '0, 32'h77005555, 1, 4'h0, 14'h0, '0));
        tbl.push_back(mk(0, NS, 0, SW, 16'h0010, '0, '0, 1, 4'b0011, 14'h0, 32'h00005555));
        tbl.push_back(mk(1, ID, 0, SW, 16'h0000, '0, '0, 0, 4'h0, '0, '0));

        foreach (tbl[i]) begin
            drive(tbl[i].sel, tbl[i].trans, tbl[i].wr, tbl[i].size, tbl[i].addr,
                  prev_wr ? prev_wd : 32'h0);
            cur_rd = dp_rd;
            is_rd  = tbl[i].sel & tbl[i].trans[1] & ~tbl[i].wr;
            if (is_rd) exp_q.push_back(tbl[i].erd);
            dp_rd   = is_rd;
            prev_wr = tbl[i].sel & tbl[i].trans[1] & tbl[i].wr;
            prev_wd = tbl[i].wdata;
            @(negedge clk);
            nm = $sformatf("row%0d", i);
            if (cur_rd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s scoreboard empty: got %h, expected a queued read", nm,
                             ram_hrdata);
                end else begin
                    check({nm, " hrdata"}, ram_hrdata, exp_q.pop_front());
                end
            end else begin
                check({nm, " hrdata idle"}, ram_hrdata, 32'h0);
            end
            check({nm, " memcs"}, 32'(ram_cs), 32'(tbl[i].ecs));
            check({nm, " memwren"}, 32'(ram_wren), 32'(tbl[i].ewren));
            if (tbl[i].ecs) check({nm, " memaddr"}, 32'(ram_maddr), 32'(tbl[i].emaddr));
            if (tbl[i].ewren != 4'h0) check({nm, " memwdata"}, ram_mwdata, tbl[i].emwdata);
            check({nm, " hreadyout"}, 32'(ram_hreadyout), 32'h1);
            check({nm, " hresp"}, 32'(ram_hresp), 32'h0);
        end
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        check("mem 0x10", ram_mem[14'h4], 32'h12345678);
        check("mem 0x20", ram_mem[14'h8], 32'hAABBCCDD);
        check("mem 0x30", ram_mem[14'hC], 32'h1122EE44);
        check("mem 0x40", ram_mem[14'h10], 32'hBEEF0000);
        check("mem 0x00", ram_mem[14'h0], 32'h77005555);

        // ROM: a write gets a two-cycle ERROR and never reaches memory
        use_rom = 1'b1;
        drive(1, NS, 1, SW, 16'h0004, 32'h0);
        @(negedge clk);
        check("rom aphase hreadyout", 32'(rom_hreadyout), 32'h1);
        check("rom aphase hresp", 32'(rom_hresp), 32'h0);
        check("rom aphase wren", 32'(rom_wren), 32'h0);
        drive(1, ID, 0, SW, 16'h0000, 32'h12345678);
        @(negedge clk);
        check("rom err1 hreadyout", 32'(rom_hreadyout), 32'h0);
        check("rom err1 hresp", 32'(rom_hresp), 32'h1);
        check("rom err1 wren", 32'(rom_wren), 32'h0);
        drive(1, NS, 0, SW, 16'h0004, 32'h12345678);
        @(negedge clk);
        check("rom err2 hreadyout", 32'(rom_hreadyout), 32'h1);
        check("rom err2 hresp", 32'(rom_hresp), 32'h1);
        check("rom err2 memcs", 32'(rom_cs), 32'h1);
        check("rom err2 memaddr", 32'(rom_maddr), 32'h1);
        check("rom err2 wren", 32'(rom_wren), 32'h0);
        drive(1, ID, 0, SW, 16'h0000, 32'h0);
        @(negedge clk);
        check("rom read hrdata", rom_hrdata, 32'hCAFE0001);
        check("rom idle hresp", 32'(rom_hresp), 32'h0);
        check("rom idle hreadyout", 32'(rom_hreadyout), 32'h1);
        check("rom word unchanged", rom_mem[14'h1], 32'hCAFE0001);

        // Async reset with a buffered write pending drops the write
        use_rom = 1'b0;
        drive(1, NS, 1, SW, 16'h0050, 32'h0);
        drive(1, NS, 0, SW, 16'h0000, 32'hDEADBEEF);
        drive(0, ID, 0, SW, 16'h0000, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_ram_reset("async reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(1, ID, 0, SW, 16'h0000, 32'h0);
        @(negedge clk);
        check("dropped write 0x50", ram_mem[14'h14], 32'h0);
        check("mem 0x00 after reset", ram_mem[14'h0], 32'h77005555);
        check("post reset memcs", 32'(ram_cs), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmsdk_ahb_to_fpga_mem.md
# cmsdk_ahb_to_fpga_mem

AHB-Lite slave that converts bus transfers into the synchronous single-port word/byte-lane interface of the FPGA block-memory models (ROM and RAM). It sits directly upstream of the block memory. It issues reads in the AHB address phase, so read data returns in the data phase with zero wait states. Writes are committed directly or through a one-entry write buffer with read-after-write merging. A ROM build option answers all writes with an ERROR response.

## Interface
- AW, 16: byte address width; the memory has 2^(AW-2) words.
- WRITE_EN, 1: 1 = RAM behaviour; 0 = ROM behaviour (writes get ERROR, memory is never written).

Ports:
- HCLK  in  1  single clock; the memory uses the same clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  write/read.
- HADDR  in  AW  byte address.
- HWDATA  in  32  write data, data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- MEMADDR  out  AW-2  word address to memory.
- MEMWDATA  out  32  write data to memory.
- MEMWREN  out  4  byte write enables.
- MEMCS  out  1  memory chip select.
- MEMRDATA  in  32  memory read data, valid one cycle after MEMCS/MEMADDR.

## Operation
- Valid transfer: HSEL & HREADY & HTRANS[1]. IDLE/BUSY transfers get OKAY with zero wait states.
- Lane decode from HSIZE/HADDR[1:0]:
  - byte: one lane, HADDR[1:0].
  - half: 4'b0011 or 4'b1100, chosen by HADDR[1].
  - word or HSIZE>2: 4'b1111.
- Read address phase:
  - MEMCS=1, MEMADDR=HADDR[AW-1:2], MEMWREN=0, all combinational.
  - HRDATA in the data phase is MEMRDATA merged with the buffer (see below).
- Write address phase: register word address and lanes into wr_addr/wr_lanes, and set wr_dphase.
- Write data phase (WRITE_EN=1):
  - No concurrent read address phase: direct write. MEMCS=1, MEMADDR=wr_addr, MEMWDATA=HWDATA, MEMWREN=wr_lanes.
  - Concurrent read address phase: capture HWDATA into buf_data and set buf_pend.
- Buffer commit: in any cycle with buf_pend=1 and no read address phase, drive MEMCS=1, MEMADDR=wr_addr, MEMWDATA=buf_data, MEMWREN=wr_lanes, then clear buf_pend.
- Invariants:
  - A write address phase is never a read cycle, so the buffer is always empty by the next write data phase.
  - At most one memory access occurs per cycle.
- Read merge:
  - At a read address phase, register hit = (HADDR[AW-1:2]==wr_addr) & (buf_pend | wr_dphase).
  - In the data phase, each byte lane set in wr_lanes comes from buf_data when hit=1; all other lanes come from MEMRDATA.
- ROM mode (WRITE_EN=0):
  - A write address phase enters state ERR1, then ERR2, then returns to IDLE.
  - No buffer update; MEMWREN stays 0 always.
- Response state machine:
  - IDLE: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - A transfer presented during ERR2 is sampled normally.
- HRDATA is 0 outside a read data phase.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - MEMCS=0, MEMWREN=0, MEMADDR=0, MEMWDATA=0.
  - buf_pend=0, wr_dphase=0, state IDLE.
- Asynchronous reset mid-operation drops any pending buffered write; that memory word is left unchanged.
- Read latency: address phase to HRDATA valid is 1 cycle, with zero wait states.
- Write latency: the memory is written in the data-phase cycle, or in the first later cycle with no read address phase. Bus-side the write is always zero-wait.
- Back-to-back reads indefinitely postpone a buffered write; merge keeps reads coherent.
- ERROR: exactly 2 cycles, the first with HREADYOUT=0.
- MEM* outputs are combinational from AHB inputs and internal registers. There are no combinational paths from MEMRDATA except to HRDATA.

## Test plan
- Word write 0x12345678 to 0x0010, then IDLE, then read 0x0010 -> memory written in the data phase with MEMWREN=4'hF; read returns 0x12345678 with HREADYOUT=1 throughout.
- Word write 0xAABBCCDD to 0x0020 with a read of 0x0020 in its data phase -> write buffered, no MEMWREN that cycle; HRDATA=0xAABBCCDD via merge; commit occurs on the next non-read cycle.
- Memory word 0x11223344 at 0x0030; byte write 0xEE to 0x0031 followed by a pipelined word read of 0x0030 -> HRDATA=0x1122EE44; memory later holds 0x1122EE44.
- Halfword write 0xBEEF to 0x0042 followed by 5 consecutive reads of other addresses -> MEMWREN=0 until the first idle cycle, then MEMWREN=4'b1100 with MEMADDR=0x10.
- WRITE_EN=0, write to 0x0004 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles; MEMWREN never nonzero; a subsequent read returns the original contents.
- Buffered write pending, HRESET pulsed asynchronously between clock edges -> all outputs at reset values immediately; the target word is unchanged after reset.
